obi_to_axil_bridge: RTL and testbench
=====================================

Name: obi_to_axil_bridge

Overview:
- Converts one cv32e40p OBI port (instruction or data) into an AXI4-Lite master.
- Sits directly upstream of the on-chip RAM and peripheral AXI4-Lite slaves.
- Supports one outstanding transaction.
- AW and W channels are tracked independently, so slaves that accept them on different cycles work as well as slaves that accept both together.

Parameters:
- ADDR_ALIGN_MASK, 32'hFFFF_FFFC, AND-mask applied to the OBI address before issue to AXI (word alignment).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- obi_req_i  input  1  OBI request
- obi_gnt_o  output  1  OBI grant
- obi_addr_i  input  32  byte address
- obi_we_i  input  1  1=write, 0=read
- obi_be_i  input  4  byte enables
- obi_wdata_i  input  32  write data
- obi_rvalid_o  output  1  response valid (one-cycle pulse)
- obi_rdata_o  output  32  read data
- obi_err_o  output  1  response error
- m_axi_awaddr  output  32  write address
- m_axi_awvalid  output  1  write address valid
- m_axi_awready  input  1  write address ready
- m_axi_wdata  output  32  write data
- m_axi_wstrb  output  4  write strobes
- m_axi_wvalid  output  1  write data valid
- m_axi_wready  input  1  write data ready
- m_axi_bresp  input  2  write response; tie 2'b00 for slaves without it
- m_axi_bvalid  input  1  write response valid
- m_axi_bready  output  1  write response ready
- m_axi_araddr  output  32  read address
- m_axi_arvalid  output  1  read address valid
- m_axi_arready  input  1  read address ready
- m_axi_rdata  input  32  read data
- m_axi_rresp  input  2  read response; tie 2'b00 for slaves without it
- m_axi_rvalid  input  1  read data valid
- m_axi_rready  output  1  read data ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE.
  - All AXI valid/ready outputs = 0.
  - obi_rvalid_o = 0, obi_err_o = 0, obi_rdata_o = 0.
  - aw_done = w_done = 0.
- Reset asserted mid-transaction: every output drops immediately. The in-flight transaction is abandoned with no OBI response.
- obi_gnt_o = obi_req_i while state == IDLE, else 0. This is combinational.
- On grant, register the following, then go to WR_ADDR if obi_we_i else RD_ADDR:
  - addr & ADDR_ALIGN_MASK
  - be
  - wdata
  - we
- WR_ADDR:
  - m_axi_awvalid = !aw_done; m_axi_wvalid = !w_done.
  - Set aw_done on awvalid&&awready; set w_done on wvalid&&wready.
  - When both handshakes are complete (including both in the same cycle), go to WR_RESP and clear the done flags.
  - AWADDR/WDATA/WSTRB are held stable while the corresponding valid is high.
- WR_RESP: m_axi_bready = 1. On bvalid, go to RESP and latch err = bresp[1].
- RD_ADDR: m_axi_arvalid = 1. On arready, go to RD_DATA.
- RD_DATA: m_axi_rready = 1. On rvalid, latch rdata and err = rresp[1], then go to RESP.
- RESP:
  - obi_rvalid_o = 1 for exactly one cycle, with obi_rdata_o and obi_err_o valid.
  - Next state is IDLE.
  - obi_rdata_o = 0 for writes.
  - obi_rdata_o holds its value after the pulse; only the pulse qualifies it.
- Latency with a zero-wait slave (grant in cycle 0):
  - AXI request in cycle 1.
  - AXI response in cycle 2.
  - obi_rvalid_o in cycle 3.
  - Next grant possible in cycle 4.
- Arbitrary slave stalls on any channel extend the corresponding state indefinitely. There is no timeout.
- AXI valid signals are never withdrawn before their handshake. They are never asserted for a second transaction before the current OBI response.
- obi_req_i may drop or change while the bridge is busy; only the registered copy is used.

Test Plan:
- Read, zero-wait slave: req addr=0x0000_0104 -> araddr=0x0000_0104 in cycle 1; rdata=0xA5A5_1234 returned, obi_rvalid_o pulse in cycle 3, obi_err_o=0.
- Write, unaligned address: addr=0x0000_0013, be=4'b0100, wdata=0x00CC_0000 -> awaddr=0x0000_0010, wstrb=4'b0100; after bvalid, one obi_rvalid_o pulse with rdata=0.
- Split AW/W acceptance: awready high in cycle 1, wready delayed to cycle 4 -> awvalid deasserts after cycle 1, wvalid held until cycle 4, bready asserted from cycle 5, exactly one response.
- Slave error: rresp=2'b10 on a read -> obi_err_o=1 with the rvalid pulse; next transaction reports obi_err_o=0.
- Back-to-back: write 0xDEAD_BEEF to 0x20 then read 0x20 against the RAM model -> read returns 0xDEAD_BEEF; second grant no earlier than cycle 4 after the first.
- Reset mid-read: assert rst_n=0 while in RD_DATA -> arvalid, rready and obi_rvalid_o are 0 immediately; after release, a new read completes normally.

Source files
------------

// File: rtl/obi_to_axil_bridge.sv
// -----------------------------------------------------------------------------
// obi_to_axil_bridge
//
// Converts one cv32e40p OBI port (instruction or data) into an AXI4-Lite
// master with a single outstanding transaction. AW and W are tracked
// independently, so slaves may accept them together or on separate cycles.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   obi_req_i/gnt_o     OBI request / combinational grant (only in IDLE)
//   obi_addr_i/we_i/be_i/wdata_i
//                       OBI request fields, captured on grant
//   obi_rvalid_o        one-cycle response pulse qualifying rdata/err
//   obi_rdata_o         read data (0 for writes), held after the pulse
//   obi_err_o           response error (bresp[1] / rresp[1])
//   m_axi_aw*/w*/b*     AXI4-Lite write address, data and response channels
//   m_axi_ar*/r*        AXI4-Lite read address and data channels
// -----------------------------------------------------------------------------
module obi_to_axil_bridge #(
  parameter logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  // OBI slave side
  input  logic        obi_req_i,
  output logic        obi_gnt_o,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  // AXI4-Lite master side
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_ok;
  logic w_w_ok;

  // Only the MSB of each response encodes an error (SLVERR/DECERR).
  logic w_unused;
  assign w_unused = ^{m_axi_bresp[0], m_axi_rresp[0]};

  assign obi_gnt_o = obi_req_i && (r_state == S_IDLE);

  assign w_aw_hs = r_awvalid && m_axi_awready;
  assign w_w_hs  = r_wvalid && m_axi_wready;
  // A channel counts as done if it completed earlier or completes this cycle.
  assign w_aw_ok = r_aw_done || w_aw_hs;
  assign w_w_ok  = r_w_done || w_w_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so obi_rdata_o and the AXI
      // address/data buses come up as 0 rather than X after reset.
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the default below is
      // overridden by a later assignment in the same cycle where needed.
      r_rvalid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (obi_req_i) begin
            r_addr  <= obi_addr_i & ADDR_ALIGN_MASK;
            r_wdata <= obi_wdata_i;
            r_be    <= obi_be_i;
            if (obi_we_i) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_ADDR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR_ADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_ok && w_w_ok) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            r_bready <= 1'b0;
            r_err    <= m_axi_bresp[1];
            r_rdata  <= '0;
            r_rvalid <= 1'b1;
            r_state  <= S_RESP;
          end
        end
        S_RD_ADDR: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi_rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= m_axi_rdata;
            r_err    <= m_axi_rresp[1];
            r_rvalid <= 1'b1;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          // obi_rvalid_o was raised on entry and drops via the default above.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_axi_awaddr  = r_addr;
  assign m_axi_araddr  = r_addr;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_be;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign obi_rvalid_o  = r_rvalid;
  assign obi_rdata_o   = r_rdata;
  assign obi_err_o     = r_err;

endmodule

// File: tb/tb_obi_to_axil_bridge.sv
// -----------------------------------------------------------------------------
// tb_obi_to_axil_bridge
//
// Directed bench for obi_to_axil_bridge. The AXI slave side is driven by hand
// cycle by cycle; outputs are sampled 1 time unit after each rising edge.
// Cycle numbers in comments are relative to the grant cycle (cycle 0).
// -----------------------------------------------------------------------------
module tb_obi_to_axil_bridge;

  logic        clk;
  logic        rst_n;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int g1     = 0;
  int g2     = 0;
  logic [31:0] ram [0:63];

  obi_to_axil_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    obi_req_i = 1'b0; obi_addr_i = '0; obi_we_i = 1'b0; obi_be_i = '0; obi_wdata_i = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;
    for (int i = 0; i < 64; i++) ram[i] = '0;

    // ---------------- Reset state ----------------
    step(); step();
    check1("rst_awvalid", m_axi_awvalid, 1'b0);
    check1("rst_wvalid", m_axi_wvalid, 1'b0);
    check1("rst_bready", m_axi_bready, 1'b0);
    check1("rst_arvalid", m_axi_arvalid, 1'b0);
    check1("rst_rready", m_axi_rready, 1'b0);
    check1("rst_rvalid", obi_rvalid_o, 1'b0);
    check1("rst_err", obi_err_o, 1'b0);
    check32("rst_rdata", obi_rdata_o, 32'h0);
    rst_n = 1'b1;
    step();
    check1("idle_gnt_noreq", obi_gnt_o, 1'b0);

    // ---------------- Read, zero-wait slave ----------------
    obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = 32'h0000_0104;
    #1 check1("rd_gnt_c0", obi_gnt_o, 1'b1);
    step();                                           // cycle 1
    check1("rd_gnt_busy", obi_gnt_o, 1'b0);
    obi_req_i = 1'b0;
    check1("rd_arvalid_c1", m_axi_arvalid, 1'b1);
    check32("rd_araddr_c1", m_axi_araddr, 32'h0000_0104);
    m_axi_arready = 1'b1;
    step();                                           // cycle 2
    m_axi_arready = 1'b0;
    check1("rd_arvalid_c2", m_axi_arvalid, 1'b0);
    check1("rd_rready_c2", m_axi_rready, 1'b1);
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hA5A5_1234; m_axi_rresp = 2'b00;
    step();                                           // cycle 3
    m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0;
    check1("rd_rvalid_c3", obi_rvalid_o, 1'b1);
    check32("rd_rdata_c3", obi_rdata_o, 32'hA5A5_1234);
    check1("rd_err_c3", obi_err_o, 1'b0);
    check1("rd_rready_c3", m_axi_rready, 1'b0);
    step();                                           // cycle 4
    check1("rd_rvalid_c4", obi_rvalid_o, 1'b0);
    check32("rd_rdata_hold", obi_rdata_o, 32'hA5A5_1234);

    // ---------------- Write, unaligned address ----------------
    obi_req_i = 1'b1; obi_we_i = 1'b1; obi_addr_i = 32'h0000_0013;
    obi_be_i = 4'b0100; obi_wdata_i = 32'h00CC_0000;
    #1 check1("wr_gnt_c0", obi_gnt_o, 1'b1);
    step();
    obi_req_i = 1'b0; obi_wdata_i = 32'hFFFF_FFFF;
    check1("wr_awvalid_c1", m_axi_awvalid, 1'b1);
    check1("wr_wvalid_c1", m_axi_wvalid, 1'b1);
    check32("wr_awaddr", m_axi_awaddr, 32'h0000_0010);
    check32("wr_wstrb", {28'h0, m_axi_wstrb}, 32'h4);
    check32("wr_wdata", m_axi_wdata, 32'h00CC_0000);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    step();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    check1("wr_awvalid_c2", m_axi_awvalid, 1'b0);
    check1("wr_wvalid_c2", m_axi_wvalid, 1'b0);
    check1("wr_bready_c2", m_axi_bready, 1'b1);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
    step();
    m_axi_bvalid = 1'b0;
    check1("wr_rvalid_c3", obi_rvalid_o, 1'b1);
    check32("wr_rdata_zero", obi_rdata_o, 32'h0);
    check1("wr_err_c3", obi_err_o, 1'b0);
    step();
    check1("wr_rvalid_c4", obi_rvalid_o, 1'b0);

    // ---------------- Split AW/W acceptance ----------------
    obi_req_i = 1'b1; obi_we_i = 1'b1; obi_addr_i = 32'h0000_0040;
    obi_be_i = 4'b1111; obi_wdata_i = 32'h1122_3344;
    step();                                           // cycle 1
    obi_req_i = 1'b0;
    check1("sp_awvalid_c1", m_axi_awvalid, 1'b1);
    check1("sp_wvalid_c1", m_axi_wvalid, 1'b1);
    m_axi_awready = 1'b1;
    step();                                           // cycle 2
    m_axi_awready = 1'b0;
    check1("sp_awvalid_c2", m_axi_awvalid, 1'b0);
    check1("sp_wvalid_c2", m_axi_wvalid, 1'b1);
    check1("sp_bready_c2", m_axi_bready, 1'b0);
    step();                                           // cycle 3
    check1("sp_wvalid_c3", m_axi_wvalid, 1'b1);
    check1("sp_awvalid_c3", m_axi_awvalid, 1'b0);
    step();                                           // cycle 4
    check1("sp_wvalid_c4", m_axi_wvalid, 1'b1);
    check32("sp_wdata_c4", m_axi_wdata, 32'h1122_3344);
    m_axi_wready = 1'b1;
    step();                                           // cycle 5
    m_axi_wready = 1'b0;
    check1("sp_wvalid_c5", m_axi_wvalid, 1'b0);
    check1("sp_bready_c5", m_axi_bready, 1'b1);
    step();                                           // cycle 6: B stalled
    check1("sp_bready_c6", m_axi_bready, 1'b1);
    check1("sp_rvalid_c6", obi_rvalid_o, 1'b0);
    m_axi_bvalid = 1'b1;
    step();                                           // cycle 7
    m_axi_bvalid = 1'b0;
    check1("sp_rvalid_c7", obi_rvalid_o, 1'b1);
    step();                                           // cycle 8
    check1("sp_rvalid_c8", obi_rvalid_o, 1'b0);
    check1("sp_bready_c8", m_axi_bready, 1'b0);

    // ---------------- Slave error on read, then clean read with AR stall ----------------
    obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = 32'h0000_0200;
    step();
    obi_req_i = 1'b0;
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hBAD0_BAD0; m_axi_rresp = 2'b10;
    step();
    m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00;
    check1("er_rvalid", obi_rvalid_o, 1'b1);
    check1("er_err", obi_err_o, 1'b1);
    step();
    obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = 32'h0000_0204;
    step();                                           // cycle 1, arready held low
    obi_req_i = 1'b0;
    step();                                           // cycle 2
    check1("er2_arvalid_stall", m_axi_arvalid, 1'b1);
    check32("er2_araddr", m_axi_araddr, 32'h0000_0204);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_5555; m_axi_rresp = 2'b00;
    step();
    m_axi_rvalid = 1'b0;
    check1("er2_rvalid", obi_rvalid_o, 1'b1);
    check1("er2_err_clear", obi_err_o, 1'b0);
    check32("er2_rdata", obi_rdata_o, 32'h0000_5555);
    step();

    // ---------------- Back-to-back write then read via RAM model ----------------
    obi_req_i = 1'b1; obi_we_i = 1'b1; obi_addr_i = 32'h0000_0020;
    obi_be_i = 4'b1111; obi_wdata_i = 32'hDEAD_BEEF;
    #1 check1("bb_gnt_wr", obi_gnt_o, 1'b1);
    g1 = cyc;
    step();                                           // cycle 1
    obi_addr_i = 32'h0000_0999; obi_wdata_i = 32'h0;  // request left high, fields scrambled
    check1("bb_gnt_c1", obi_gnt_o, 1'b0);
    if (m_axi_awvalid && m_axi_wvalid) ram[m_axi_awaddr[7:2]] = m_axi_wdata;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    step();                                           // cycle 2
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    check1("bb_gnt_c2", obi_gnt_o, 1'b0);
    m_axi_bvalid = 1'b1;
    step();                                           // cycle 3
    m_axi_bvalid = 1'b0;
    check1("bb_gnt_c3", obi_gnt_o, 1'b0);
    check1("bb_wr_rvalid", obi_rvalid_o, 1'b1);
    step();                                           // cycle 4
    obi_we_i = 1'b0; obi_addr_i = 32'h0000_0020;
    #1 check1("bb_gnt_rd", obi_gnt_o, 1'b1);
    g2 = cyc;
    check32("bb_grant_gap", 32'(g2 - g1), 32'd4);
    step();
    obi_req_i = 1'b0;
    check32("bb_araddr", m_axi_araddr, 32'h0000_0020);
    m_axi_arready = 1'b1;
    m_axi_rdata = ram[m_axi_araddr[7:2]];
    step();
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1;
    step();
    m_axi_rvalid = 1'b0;
    check1("bb_rd_rvalid", obi_rvalid_o, 1'b1);
    check32("bb_rd_rdata", obi_rdata_o, 32'hDEAD_BEEF);
    step();

    // ---------------- Reset mid-read ----------------
    obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = 32'h0000_0300;
    step();
    obi_req_i = 1'b0;
    m_axi_arready = 1'b1;
    step();                                           // now in RD_DATA
    m_axi_arready = 1'b0;
    check1("mr_rready_pre", m_axi_rready, 1'b1);
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h7777_7777;
    #2 rst_n = 1'b0;
    #1;
    check1("mr_arvalid", m_axi_arvalid, 1'b0);
    check1("mr_rready", m_axi_rready, 1'b0);
    check1("mr_rvalid", obi_rvalid_o, 1'b0);
    step();
    m_axi_rvalid = 1'b0;
    step();
    check1("mr_rvalid_held", obi_rvalid_o, 1'b0);
    rst_n = 1'b1;
    step();
    obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = 32'h0000_0104;
    #1 check1("mr_gnt", obi_gnt_o, 1'b1);
    step();
    obi_req_i = 1'b0;
    check32("mr_araddr", m_axi_araddr, 32'h0000_0104);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0BAD_F00D;
    step();
    m_axi_rvalid = 1'b0;
    check1("mr_new_rvalid", obi_rvalid_o, 1'b1);
    check32("mr_new_rdata", obi_rdata_o, 32'h0BAD_F00D);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
